// File: rtl/dm_cmd_responder_pkg.sv
// Shared definitions for the DataMover command responder and its peers.
// Holds command/status bit positions, FSM encoding and a status helper.
package dm_cmd_responder_pkg;

  localparam int CMD_WIDTH      = 72;
  localparam int BTT_WIDTH      = 23;
  localparam int ADDR_WIDTH     = 32;
  localparam int TAG_WIDTH      = 4;
  localparam int DSA_WIDTH      = 6;
  localparam int RSVD_WIDTH     = 4;
  localparam int STS_WIDTH      = 8;

  localparam int CMD_BTT_LSB    = 0;
  localparam int CMD_TYPE_BIT   = 23;
  localparam int CMD_DSA_LSB    = 24;
  localparam int CMD_EOF_BIT    = 30;
  localparam int CMD_DRR_BIT    = 31;
  localparam int CMD_SADDR_LSB  = 32;
  localparam int CMD_TAG_LSB    = 64;
  localparam int CMD_RSVD_LSB   = 68;

  localparam int STS_TAG_LSB    = 0;
  localparam int STS_INTERR_BIT = 4;
  localparam int STS_DECERR_BIT = 5;
  localparam int STS_SLVERR_BIT = 6;
  localparam int STS_OKAY_BIT   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STS  = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [ADDR_WIDTH-1:0] saddr;
    logic                  eof;
    logic                  incr;
    logic [BTT_WIDTH-1:0]  btt;
  } dm_cmd_t;

  // A zero-length command is reported as an internal error, never OKAY.
  function automatic logic [STS_WIDTH-1:0] dm_sts_byte(
    input logic [TAG_WIDTH-1:0] tag,
    input logic                 interr
  );
    logic [STS_WIDTH-1:0] s;
    s = '0;
    s[STS_TAG_LSB +: TAG_WIDTH] = tag;
    s[STS_INTERR_BIT] = interr;
    s[STS_DECERR_BIT] = 1'b0;
    s[STS_SLVERR_BIT] = 1'b0;
    s[STS_OKAY_BIT]   = ~interr;
    return s;
  endfunction

endpackage

// File: rtl/dm_pattern_gen.sv
// Combinational beat generator: byte lane i carries (addr + i)[7:0].
// Ports: addr (beat base address LSBs), rem (bytes left) -> data, keep.
module dm_pattern_gen
  import dm_cmd_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic [7:0]            addr,
  input  logic [BTT_WIDTH-1:0]  rem,
  output logic [DATA_WIDTH-1:0] data,
  output logic [KEEP_WIDTH-1:0] keep
);

  // Lane i is live while more than i bytes remain; dead lanes drive 0.
  always_comb begin
    data = '0;
    keep = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep[i] = (rem > BTT_WIDTH'(i));
      if (keep[i]) begin
        data[8*i +: 8] = addr + 8'(i);
      end
    end
  end

endmodule

// File: rtl/dm_cmd_responder.sv
// DataMover read-command responder: accepts a command, emits a synthetic
// data stream, then one status byte. Ports: cmd slave, data/sts masters.
module dm_cmd_responder
  import dm_cmd_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [71:0]           s_axis_cmd_tdata,
  input  logic                  s_axis_cmd_tvalid,
  output logic                  s_axis_cmd_tready,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_data_tkeep,
  output logic                  m_axis_data_tlast,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic [7:0]            m_axis_sts_tdata,
  output logic                  m_axis_sts_tkeep,
  output logic                  m_axis_sts_tlast,
  output logic                  m_axis_sts_tvalid,
  input  logic                  m_axis_sts_tready
);

  localparam logic [BTT_WIDTH-1:0]  KW_BYTES = BTT_WIDTH'(KEEP_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] KW_ADDR  = ADDR_WIDTH'(KEEP_WIDTH);

  dm_state_e             state;
  dm_cmd_t               cmd;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [BTT_WIDTH-1:0]  cur_rem;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  eof_q;
  logic                  incr_q;

  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [BTT_WIDTH-1:0]  nxt_rem;
  logic [ADDR_WIDTH-1:0] pg_addr;
  logic [BTT_WIDTH-1:0]  pg_rem;
  logic                  pg_last;
  logic [DATA_WIDTH-1:0] pg_data;
  logic [KEEP_WIDTH-1:0] pg_keep;

  logic                  cmd_fire;
  logic                  data_fire;
  logic                  sts_fire;
  logic                  unused_cmd_bits;

  assign cmd.btt   = s_axis_cmd_tdata[CMD_BTT_LSB +: BTT_WIDTH];
  assign cmd.incr  = s_axis_cmd_tdata[CMD_TYPE_BIT];
  assign cmd.eof   = s_axis_cmd_tdata[CMD_EOF_BIT];
  assign cmd.saddr = s_axis_cmd_tdata[CMD_SADDR_LSB +: ADDR_WIDTH];
  assign cmd.tag   = s_axis_cmd_tdata[CMD_TAG_LSB +: TAG_WIDTH];

  assign unused_cmd_bits = ^{
    s_axis_cmd_tdata[CMD_DSA_LSB +: DSA_WIDTH],
    s_axis_cmd_tdata[CMD_DRR_BIT],
    s_axis_cmd_tdata[CMD_RSVD_LSB +: RSVD_WIDTH]
  };

  // Gating with rst keeps ready low in the reset cycle itself.
  assign s_axis_cmd_tready = (state == ST_IDLE) && !rst;

  assign cmd_fire  = s_axis_cmd_tvalid && s_axis_cmd_tready;
  assign data_fire = m_axis_data_tvalid && m_axis_data_tready;
  assign sts_fire  = m_axis_sts_tvalid && m_axis_sts_tready;

  assign nxt_addr = incr_q ? cur_addr + KW_ADDR : cur_addr;
  assign nxt_rem  = (cur_rem > KW_BYTES) ? cur_rem - KW_BYTES : '0;

  // The generator always looks one beat ahead: the command itself in
  // IDLE, the beat following the current one in DATA.
  assign pg_addr = (state == ST_IDLE) ? cmd.saddr : nxt_addr;
  assign pg_rem  = (state == ST_IDLE) ? cmd.btt : nxt_rem;
  assign pg_last = (pg_rem <= KW_BYTES);

  dm_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_pattern_gen (
    .addr (pg_addr[7:0]),
    .rem  (pg_rem),
    .data (pg_data),
    .keep (pg_keep)
  );

  assign m_axis_sts_tkeep = m_axis_sts_tvalid;
  assign m_axis_sts_tlast = m_axis_sts_tvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      cur_addr           <= '0;
      cur_rem            <= '0;
      tag_q              <= '0;
      eof_q              <= 1'b0;
      incr_q             <= 1'b0;
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
      m_axis_data_tkeep  <= '0;
      m_axis_data_tlast  <= 1'b0;
      m_axis_sts_tvalid  <= 1'b0;
      m_axis_sts_tdata   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            tag_q  <= cmd.tag;
            eof_q  <= cmd.eof;
            incr_q <= cmd.incr;
            if (cmd.btt != '0) begin
              state              <= ST_DATA;
              cur_addr           <= cmd.saddr;
              cur_rem            <= cmd.btt;
              m_axis_data_tvalid <= 1'b1;
              m_axis_data_tdata  <= pg_data;
              m_axis_data_tkeep  <= pg_keep;
              m_axis_data_tlast  <= cmd.eof && pg_last;
            end else begin
              state             <= ST_STS;
              m_axis_sts_tvalid <= 1'b1;
              m_axis_sts_tdata  <= dm_sts_byte(cmd.tag, 1'b1);
            end
          end
        end
        ST_DATA: begin
          if (data_fire) begin
            cur_rem <= nxt_rem;
            if (nxt_rem == '0) begin
              state              <= ST_STS;
              m_axis_data_tvalid <= 1'b0;
              m_axis_data_tdata  <= '0;
              m_axis_data_tkeep  <= '0;
              m_axis_data_tlast  <= 1'b0;
              m_axis_sts_tvalid  <= 1'b1;
              m_axis_sts_tdata   <= dm_sts_byte(tag_q, 1'b0);
            end else begin
              cur_addr           <= nxt_addr;
              m_axis_data_tdata  <= pg_data;
              m_axis_data_tkeep  <= pg_keep;
              m_axis_data_tlast  <= eof_q && pg_last;
            end
          end
        end
        ST_STS: begin
          if (sts_fire) begin
            state             <= ST_IDLE;
            m_axis_sts_tvalid <= 1'b0;
            m_axis_sts_tdata  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cmd_responder.sv
// Randomized self-checking bench for dm_cmd_responder.
// Expected beats/status come from a byte-level model of the command.
module tb_dm_cmd_responder;

  localparam int DW = 64;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [71:0]   cmd_tdata = '0;
  logic          cmd_tvalid = 1'b0;
  logic          cmd_tready;
  logic [DW-1:0] d_tdata;
  logic [KW-1:0] d_tkeep;
  logic          d_tlast;
  logic          d_tvalid;
  logic          d_tready = 1'b0;
  logic [7:0]    s_tdata;
  logic          s_tkeep;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready = 1'b0;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  dm_cmd_responder #(.DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_cmd_tdata   (cmd_tdata),
    .s_axis_cmd_tvalid  (cmd_tvalid),
    .s_axis_cmd_tready  (cmd_tready),
    .m_axis_data_tdata  (d_tdata),
    .m_axis_data_tkeep  (d_tkeep),
    .m_axis_data_tlast  (d_tlast),
    .m_axis_data_tvalid (d_tvalid),
    .m_axis_data_tready (d_tready),
    .m_axis_sts_tdata   (s_tdata),
    .m_axis_sts_tkeep   (s_tkeep),
    .m_axis_sts_tlast   (s_tlast),
    .m_axis_sts_tvalid  (s_tvalid),
    .m_axis_sts_tready  (s_tready)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: beat k covers bytes [k*KW, k*KW+KW) of the transfer.
  task automatic exp_beat(input int k, input int nb, input int btt,
                          input bit incr, input bit eof,
                          input logic [31:0] saddr,
                          output logic [DW-1:0] d,
                          output logic [KW-1:0] kp, output logic l);
    logic [31:0] a;
    logic [31:0] b;
    int vb;
    a = incr ? saddr + 32'(k * KW) : saddr;
    vb = KW;
    if (k == nb - 1 && (btt % KW) != 0) vb = btt % KW;
    d = '0;
    kp = '0;
    for (int i = 0; i < KW; i++) begin
      if (i < vb) begin
        b = a + 32'(i);
        d[8*i +: 8] = b[7:0];
        kp[i] = 1'b1;
      end
    end
    l = eof && (k == nb - 1);
  endtask

  function automatic logic [71:0] mk_cmd(input int btt, input bit incr,
                                         input bit eof,
                                         input logic [31:0] saddr,
                                         input logic [3:0] tag);
    logic [3:0] rsvd;
    logic [5:0] dsa;
    logic drr;
    rsvd = 4'($urandom);
    dsa  = 6'($urandom);
    drr  = 1'($urandom);
    return {rsvd, tag, saddr, drr, eof, dsa, incr, 23'(btt)};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!cmd_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_tready, 1);
  endtask

  // dmode: 0 random ready, 1 always ready, 2 toggling starting low.
  task automatic run_cmd(input int btt, input bit incr, input bit eof,
                         input logic [31:0] saddr, input logic [3:0] tag,
                         input int dmode, input int hold);
    int nb;
    int k;
    int cyc;
    bit r;
    bit tog;
    logic [DW-1:0] ed;
    logic [KW-1:0] ek;
    logic el;
    logic [7:0] es;
    nb = (btt + KW - 1) / KW;
    es = (btt == 0) ? {4'h1, tag} : {4'h8, tag};
    wait_idle();
    cmd_tvalid = 1'b1;
    cmd_tdata = mk_cmd(btt, incr, eof, saddr, tag);
    @(negedge clk);
    // Junk command held valid while busy must be ignored.
    cmd_tdata = {$urandom, $urandom, 8'($urandom)};
    k = 0;
    cyc = 0;
    tog = 1'b0;
    if (nb > 0) chk("first_beat_valid", d_tvalid, 1);
    while (k < nb) begin
      chk("cmd_ready_busy", cmd_tready, 0);
      chk("d_valid", d_tvalid, 1);
      chk("s_valid_busy", s_tvalid, 0);
      exp_beat(k, nb, btt, incr, eof, saddr, ed, ek, el);
      chk("d_data", d_tdata, ed);
      chk("d_keep", d_tkeep, ek);
      chk("d_last", d_tlast, el);
      case (dmode)
        1: r = 1'b1;
        2: begin r = tog; tog = !tog; end
        default: r = 1'($urandom);
      endcase
      d_tready = r;
      @(negedge clk);
      if (r) k++;
      cyc++;
      if (cyc > 500) begin
        chk("d_timeout", 1, 0);
        break;
      end
    end
    d_tready = 1'b0;
    chk("d_valid_done", d_tvalid, 0);
    for (int h = 0; h <= hold; h++) begin
      chk("s_valid", s_tvalid, 1);
      chk("s_data", s_tdata, es);
      chk("s_keep", s_tkeep, 1);
      chk("s_last", s_tlast, 1);
      chk("cmd_ready_sts", cmd_tready, 0);
      if (h == hold) begin
        s_tready = 1'b1;
        cmd_tvalid = 1'b0;
      end
      @(negedge clk);
    end
    s_tready = 1'b0;
    chk("s_valid_done", s_tvalid, 0);
    chk("cmd_ready_after", cmd_tready, 1);
  endtask

  task automatic check_reset_outputs(input bit in_reset);
    chk("rst_cmd_ready", cmd_tready, in_reset ? 0 : 1);
    chk("rst_d_valid", d_tvalid, 0);
    chk("rst_d_data", d_tdata, 0);
    chk("rst_d_keep", d_tkeep, 0);
    chk("rst_d_last", d_tlast, 0);
    chk("rst_s_valid", s_tvalid, 0);
    chk("rst_s_data", s_tdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs(1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(1'b0);

    run_cmd(16, 1, 1, 32'h0000_1000, 4'd5, 1, 0);
    run_cmd(13, 1, 0, 32'h0000_0020, 4'd9, 1, 0);
    run_cmd(0, 1, 1, 32'h1234_5678, 4'd3, 1, 0);
    run_cmd(24, 0, 1, 32'h0000_0040, 4'd7, 2, 4);
    run_cmd(64, 1, 1, 32'hFFFF_FFF8, 4'd2, 1, 1);

    // Reset in the middle of a 4-beat transfer.
    wait_idle();
    cmd_tvalid = 1'b1;
    cmd_tdata = mk_cmd(32, 1, 1, 32'h0000_0100, 4'd6);
    @(negedge clk);
    cmd_tvalid = 1'b0;
    d_tready = 1'b1;
    chk("abort_beat1_valid", d_tvalid, 1);
    @(negedge clk);
    d_tready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(1'b0);
    run_cmd(8, 1, 1, 32'h0000_0200, 4'd1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      int btt;
      btt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 70));
      run_cmd(btt, 1'($urandom), 1'($urandom), $urandom,
              4'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
